// File: rtl/smvm_pkg.sv
// Shared types and helpers for the lane-parallel sparse matrix-vector multiplier.
// Holds the control state encoding, lane part-select offsets and a popcount.
package smvm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COLS  = 3'd1,
    S_VEC   = 3'd2,
    S_MAT   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Widest lane mask the popcount helper accepts.
  localparam int unsigned MAX_LANES = 64;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/smvm_result_fifo.sv
// Show-ahead result FIFO: up to K pushes and one pop per cycle, both honoured together.
// No internal backpressure; the producer reserves space from o_count before pushing.
module smvm_result_fifo #(
  parameter int K     = 4,
  parameter int DW    = 25,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(K+1)-1:0]     i_push_cnt,
  input  logic [K*DW-1:0]            i_push_dat,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_dat,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;

  logic [PTR_W-1:0] w_widx [K];
  logic [PTR_W-1:0] w_wr_nx;
  logic [PTR_W-1:0] w_rd_nx;
  logic             w_pop_ok;

  // Slot i of a multi-push lands i entries past the write pointer.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_widx[i] = PTR_W'((int'(r_wr) + i) % DEPTH);
    end
    w_wr_nx  = PTR_W'((int'(r_wr) + int'(i_push_cnt)) % DEPTH);
    w_rd_nx  = PTR_W'((int'(r_rd) + 1) % DEPTH);
    w_pop_ok = i_pop && (r_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= w_wr_nx;
      if (w_pop_ok) begin
        r_rd <= w_rd_nx;
      end
      r_cnt <= r_cnt + CNT_W'(i_push_cnt) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (i < int'(i_push_cnt)) begin
        r_mem[w_widx[i]] <= i_push_dat[i*DW +: DW];
      end
    end
  end

  assign o_dat   = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/smvm_lanes.sv
// K-lane CSR sparse matrix-vector multiply: header, dense vector, then nonzeros; a beat's rows reach the FIFO one edge after accept.
// in_ready in MAT is a credit check that reserves FIFO room for the beat in stage 1 plus a worst-case K-row beat.
module smvm_lanes
  import smvm_pkg::*;
#(
  parameter int K          = 4,
  parameter int VAL_W      = 8,
  parameter int COL_W      = 7,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*VAL_W-1:0]   val_in,
  input  logic [K*COL_W-1:0]   col_in,
  input  logic [K-1:0]         ipv_in,
  input  logic [K-1:0]         lane_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     data_out,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int VEC_DEPTH = 2 ** COL_W;
  localparam int PROD_W    = 2 * VAL_W;
  localparam int PC_W      = $clog2(K + 1);
  localparam int DW        = ACC_W + 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  state_t r_state;
  state_t w_state_nx;

  logic [VAL_W-1:0]        r_rows_m1;
  logic [VAL_W-1:0]        r_rcnt;
  logic [COL_W-1:0]        r_cols_m1;
  logic [COL_W-1:0]        r_vcnt;
  logic signed [VAL_W-1:0] r_vec [VEC_DEPTH];
  logic signed [ACC_W-1:0] r_carry;
  logic                    r_err;

  logic                     r_s1_vld;
  logic [K-1:0]             r_s1_ipv;
  logic [K-1:0]             r_s1_en;
  logic signed [PROD_W-1:0] r_s1_prod [K];

  logic                     w_acc;
  logic                     w_mat_acc;
  logic [VAL_W-1:0]         w_hdr;
  logic [VAL_W-1:0]         w_rows_m1;
  logic [COL_W-1:0]         w_cols_m1;
  logic [K-1:0]             w_col_bad;
  logic signed [PROD_W-1:0] w_prod [K];
  logic                     w_credit_ok;

  logic signed [ACC_W-1:0]  w_run;
  logic [PC_W-1:0]          w_npush;
  logic [VAL_W-1:0]         w_rcnt_nx;
  logic                     w_row_done;
  logic                     w_last;
  logic [K*DW-1:0]          w_push_dat;

  logic [DW-1:0]            w_fifo_dat;
  logic                     w_fifo_empty;
  logic [CNT_W-1:0]         w_fifo_cnt;
  logic                     w_pop;

  assign w_acc     = in_valid && in_ready;
  assign w_mat_acc = w_acc && (r_state == S_MAT);
  assign w_hdr     = val_in[VAL_W-1:0];

  // Header decode: rows 0 means 1, cols 0 (or anything past the RAM) means VEC_DEPTH.
  always_comb begin
    w_rows_m1 = (w_hdr == '0) ? '0 : w_hdr - VAL_W'(1);
    if (w_hdr == '0 || int'(w_hdr) > VEC_DEPTH) begin
      w_cols_m1 = '1;
    end else begin
      w_cols_m1 = COL_W'(w_hdr - VAL_W'(1));
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_lane
    logic [COL_W-1:0]         w_col;
    logic signed [VAL_W-1:0]  w_a;
    logic signed [PROD_W-1:0] w_mul;
    assign w_col        = col_in[lane_lo(g, COL_W) +: COL_W];
    assign w_a          = signed'(val_in[lane_lo(g, VAL_W) +: VAL_W]);
    assign w_mul        = w_a * r_vec[w_col];
    assign w_col_bad[g] = lane_en[g] && (w_col > r_cols_m1);
    assign w_prod[g]    = (lane_en[g] && !w_col_bad[g]) ? w_mul : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_ipv <= '0;
      r_s1_en  <= '0;
      for (int i = 0; i < K; i++) begin
        r_s1_prod[i] <= '0;
      end
    end else begin
      r_s1_vld <= w_mat_acc;
      if (w_mat_acc) begin
        r_s1_ipv  <= ipv_in & lane_en;
        r_s1_en   <= lane_en;
        r_s1_prod <= w_prod;
      end else begin
        r_s1_ipv <= '0;
        r_s1_en  <= '0;
      end
    end
  end

  // Segmented accumulate; once the final row is pushed, later lanes are dropped.
  always_comb begin
    w_run      = r_carry;
    w_npush    = '0;
    w_rcnt_nx  = r_rcnt;
    w_row_done = 1'b0;
    w_last     = 1'b0;
    w_push_dat = '0;
    if (r_s1_vld && r_state == S_MAT) begin
      for (int i = 0; i < K; i++) begin
        if (!w_row_done && r_s1_en[i]) begin
          w_run = w_run + ACC_W'(r_s1_prod[i]);
          if (r_s1_ipv[i]) begin
            w_last = (w_rcnt_nx == r_rows_m1);
            w_push_dat[int'(w_npush)*DW +: DW] = {w_last, w_run};
            w_npush    = w_npush + PC_W'(1);
            w_rcnt_nx  = w_rcnt_nx + VAL_W'(1);
            w_run      = '0;
            w_row_done = w_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows_m1 <= '0;
      r_cols_m1 <= '0;
      r_vcnt    <= '0;
      r_rcnt    <= '0;
      r_carry   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            r_rows_m1 <= w_rows_m1;
            r_rcnt    <= '0;
            r_carry   <= '0;
            r_err     <= 1'b0;
          end
          S_COLS: begin
            r_cols_m1 <= w_cols_m1;
            r_vcnt    <= '0;
          end
          S_VEC:   r_vcnt <= r_vcnt + COL_W'(1);
          default: ;
        endcase
      end
      if (w_mat_acc && (|w_col_bad)) begin
        r_err <= 1'b1;
      end
      if (r_s1_vld && r_state == S_MAT) begin
        r_rcnt  <= w_rcnt_nx;
        r_carry <= w_row_done ? '0 : w_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && r_state == S_VEC) begin
      r_vec[r_vcnt] <= signed'(w_hdr);
    end
  end

  assign w_credit_ok = (int'(w_fifo_cnt) + int'(popcount(MAX_LANES'(r_s1_ipv))) + K) <= FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nx = S_COLS;
      S_COLS:  if (w_acc) w_state_nx = S_VEC;
      S_VEC:   if (w_acc && r_vcnt == r_cols_m1) w_state_nx = S_MAT;
      S_MAT:   if (w_row_done) w_state_nx = S_DRAIN;
      S_DRAIN: if (w_fifo_empty && !r_s1_vld) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_COLS, S_VEC: in_ready = 1'b1;
      S_MAT:         in_ready = w_credit_ok;
      default:       in_ready = 1'b0;
    endcase
  end

  smvm_result_fifo #(
    .K     (K),
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_cnt (w_npush),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_dat      (w_fifo_dat),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_cnt)
  );

  assign out_valid = !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;
  assign data_out  = out_valid ? w_fifo_dat[ACC_W-1:0] : '0;
  assign out_last  = out_valid && w_fifo_dat[ACC_W];
  assign err       = r_err;

endmodule
